// File: rtl/fft_4_stream_if.sv
// Streaming sample/bin handshake bundle for fft_4_stream.
// master: upstream source and downstream sink side; slave: the transform block.
interface fft_4_stream_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_r;
  logic [DATA_WIDTH-1:0] in_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_r;
  logic [DATA_WIDTH-1:0] out_i;
  logic [1:0]            out_index;
  logic                  out_last;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_index, out_last
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_index, out_last
  );
endinterface

// File: rtl/fft_4_stream.sv
// 4-point streaming DFT: load four samples, one butterfly cycle, unload bins 0..3.
// Optional macro FFT_SCALE_EN divides every bin by 4 (floor); default keeps the low DATA_WIDTH bits.
module fft_4_stream #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  fft_4_stream_if.slave  bus
);
  localparam int unsigned SW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   load_cnt_q;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] smp_r_q [4];
  logic signed [DATA_WIDTH-1:0] smp_i_q [4];
  logic [DATA_WIDTH-1:0]        bin_r_q [4];
  logic [DATA_WIDTH-1:0]        bin_i_q [4];
  logic [DATA_WIDTH-1:0]        bin_r_d [4];
  logic [DATA_WIDTH-1:0]        bin_i_d [4];
  logic [DATA_WIDTH-1:0]        out_r_q, out_i_q;
  logic [1:0]                   out_index_q;
  logic                         out_last_q;
  logic                         accept, consume;
  logic [1:0]                   next_index;

  logic signed [SW-1:0] xr [4];
  logic signed [SW-1:0] xi [4];
  logic signed [SW-1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;

  assign accept     = bus.in_valid && in_ready_q;
  assign consume    = out_valid_q && bus.out_ready;
  assign next_index = out_index_q + 2'd1;

  function automatic logic [DATA_WIDTH-1:0] fmt(input logic signed [SW-1:0] v);
`ifdef FFT_SCALE_EN
    return DATA_WIDTH'(v >>> 2);
`else
    return DATA_WIDTH'(v);
`endif
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && load_cnt_q == 2'd3) state_d = CALC;
      CALC:    state_d = UNLOAD;
      UNLOAD:  if (consume && out_index_q == 2'd3) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they come straight from flops
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      LOAD:    in_ready_d  = 1'b1;
      UNLOAD:  out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        smp_r_q[k] <= '0;
        smp_i_q[k] <= '0;
      end
    end else if (accept) begin
      smp_r_q[load_cnt_q] <= bus.in_r;
      smp_i_q[load_cnt_q] <= bus.in_i;
      load_cnt_q          <= load_cnt_q + 2'd1;
    end
  end

  // Radix-4 butterfly at DATA_WIDTH+2 bits, adders only
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xr[k] = SW'(smp_r_q[k]);
      xi[k] = SW'(smp_i_q[k]);
    end
    a_r = xr[0] + xr[2];
    a_i = xi[0] + xi[2];
    b_r = xr[0] - xr[2];
    b_i = xi[0] - xi[2];
    c_r = xr[1] + xr[3];
    c_i = xi[1] + xi[3];
    d_r = xr[1] - xr[3];
    d_i = xi[1] - xi[3];
    bin_r_d[0] = fmt(a_r + c_r);
    bin_i_d[0] = fmt(a_i + c_i);
    bin_r_d[1] = fmt(b_r + d_i);
    bin_i_d[1] = fmt(b_i - d_r);
    bin_r_d[2] = fmt(a_r - c_r);
    bin_i_d[2] = fmt(a_i - c_i);
    bin_r_d[3] = fmt(b_r - d_i);
    bin_i_d[3] = fmt(b_i + d_r);
  end

  // Bin storage and output holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        bin_r_q[k] <= '0;
        bin_i_q[k] <= '0;
      end
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_index_q <= 2'd0;
      out_last_q  <= 1'b0;
    end else if (state_q == CALC) begin
      for (int k = 0; k < 4; k++) begin
        bin_r_q[k] <= bin_r_d[k];
        bin_i_q[k] <= bin_i_d[k];
      end
      out_r_q     <= bin_r_d[0];
      out_i_q     <= bin_i_d[0];
      out_index_q <= 2'd0;
      out_last_q  <= 1'b0;
    end else if (consume && out_index_q != 2'd3) begin
      out_r_q     <= bin_r_q[next_index];
      out_i_q     <= bin_i_q[next_index];
      out_index_q <= next_index;
      out_last_q  <= (next_index == 2'd3);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_fft_4_stream.sv
// Scoreboard bench for fft_4_stream: reference DFT model feeds a queue, monitor pops on each consumed bin.
module tb_fft_4_stream;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_4_stream_if #(.DATA_WIDTH(DW)) bus_if ();

  fft_4_stream #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic [1:0]    idx;
    logic          last;
  } bin_t;

  bin_t sb_q[$];
  bin_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   fr_r[4];
  int   fr_i[4];
  int   fr_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] scl(input int v);
`ifdef FFT_SCALE_EN
    return DW'(v >>> 2);
`else
    return DW'(v);
`endif
  endfunction

  // Direct DFT formulas on integers
  function automatic void push_frame();
    int er[4];
    int ei[4];
    bin_t b;
    er[0] = fr_r[0] + fr_r[1] + fr_r[2] + fr_r[3];
    ei[0] = fr_i[0] + fr_i[1] + fr_i[2] + fr_i[3];
    er[1] = (fr_r[0] - fr_r[2]) + (fr_i[1] - fr_i[3]);
    ei[1] = (fr_i[0] - fr_i[2]) - (fr_r[1] - fr_r[3]);
    er[2] = (fr_r[0] + fr_r[2]) - (fr_r[1] + fr_r[3]);
    ei[2] = (fr_i[0] + fr_i[2]) - (fr_i[1] + fr_i[3]);
    er[3] = (fr_r[0] - fr_r[2]) - (fr_i[1] - fr_i[3]);
    ei[3] = (fr_i[0] - fr_i[2]) + (fr_r[1] - fr_r[3]);
    for (int k = 0; k < 4; k++) begin
      b.r    = scl(er[k]);
      b.i    = scl(ei[k]);
      b.idx  = 2'(k);
      b.last = (k == 3);
      sb_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid) begin
      check("in_ready_in_unload", 32'(bus_if.in_ready), 32'd0);
      if (bus_if.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_depth", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("bin_r",     32'(bus_if.out_r),     32'(mon_e.r));
          check("bin_i",     32'(bus_if.out_i),     32'(mon_e.i));
          check("bin_index", 32'(bus_if.out_index), 32'(mon_e.idx));
          check("bin_last",  32'(bus_if.out_last),  32'(mon_e.last));
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i, input int gap);
    logic rdy;
    int   n;
    bus_if.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_r     = r;
    bus_if.in_i     = i;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    bus_if.in_valid = 1'b0;
    if (!rdy) begin
      check("send_accept", 32'(rdy), 32'd1);
    end else begin
      fr_r[fr_cnt] = int'($signed(r));
      fr_i[fr_cnt] = int'($signed(i));
      fr_cnt++;
      if (fr_cnt == 4) begin
        fr_cnt = 0;
        push_frame();
        check("calc_in_ready",  32'(bus_if.in_ready),  32'd0);
        check("calc_out_valid", 32'(bus_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("first_out_valid", 32'(bus_if.out_valid), 32'd1);
        check("first_out_index", 32'(bus_if.out_index), 32'd0);
      end
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] vr[4], input logic [DW-1:0] vi[4], input int gap);
    for (int k = 0; k < 4; k++) send(vr[k], vi[k], gap);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty",     32'(sb_q.size()),      32'd0);
    check("drain_in_ready",  32'(bus_if.in_ready),  32'd1);
    check("drain_out_valid", 32'(bus_if.out_valid), 32'd0);
  endtask

  task automatic wait_bin(input logic [1:0] k);
    int n = 0;
    while (!(bus_if.out_valid && bus_if.out_index == k) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_bin", 32'(bus_if.out_valid && bus_if.out_index == k), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_r",     32'(bus_if.out_r),     32'd0);
    check("rst_out_i",     32'(bus_if.out_i),     32'd0);
    check("rst_out_index", 32'(bus_if.out_index), 32'd0);
    check("rst_out_last",  32'(bus_if.out_last),  32'd0);
    sb_q.delete();
    fr_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    check("post_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] vr[4];
    logic [DW-1:0] vi[4];
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_r      = '0;
    bus_if.in_i      = '0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Real ramp 4,8,0,0
    vr = '{16'd4, 16'd8, 16'd0, 16'd0};
    vi = '{16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(vr, vi, 0);
    drain();

    // Full-scale positive DC
    vr = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    send_frame(vr, vi, 0);
    drain();

    // Impulse with gaps between samples
    vr = '{16'd1, 16'd0, 16'd0, 16'd0};
    vi = '{16'd1, 16'd0, 16'd0, 16'd0};
    send_frame(vr, vi, 2);
    drain();

    // Full-scale negative DC
    vr = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vi = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    send_frame(vr, vi, 1);
    drain();

    // Backpressure on bin 1 with ignored input pulses
    vr = '{16'd100, 16'hFFF6, 16'd37, 16'd5};
    vi = '{16'd3, 16'd20, 16'hFF00, 16'd7};
    send_frame(vr, vi, 0);
    wait_bin(2'd1);
    bus_if.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus_if.in_valid = (c % 2 == 0);
      bus_if.in_r     = 16'h5A5A;
      bus_if.in_i     = 16'hA5A5;
      @(posedge clk);
      #1;
      check("hold_r",        32'(bus_if.out_r),     32'(sb_q[0].r));
      check("hold_i",        32'(bus_if.out_i),     32'(sb_q[0].i));
      check("hold_index",    32'(bus_if.out_index), 32'd1);
      check("hold_valid",    32'(bus_if.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus_if.in_ready),  32'd0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    drain();

    // Reset while bin 2 is presented
    vr = '{16'd9, 16'd2, 16'hFFFD, 16'd11};
    vi = '{16'd1, 16'hFFFF, 16'd4, 16'd0};
    send_frame(vr, vi, 0);
    wait_bin(2'd2);
    bus_if.out_ready = 1'b0;
    do_reset();
    bus_if.out_ready = 1'b1;
    vr = '{16'd6, 16'd1, 16'd2, 16'd3};
    vi = '{16'd0, 16'd5, 16'hFFFE, 16'd1};
    send_frame(vr, vi, 0);
    drain();

    // Reset with a partial frame loaded
    send(16'd1000, 16'd1000, 0);
    send(16'd2000, 16'd2000, 0);
    do_reset();
    vr = '{16'd7, 16'd0, 16'd0, 16'd0};
    vi = '{16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(vr, vi, 0);
    drain();

    // Random frames with random gaps
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) begin
        vr[k] = DW'($urandom);
        vi[k] = DW'($urandom);
      end
      send_frame(vr, vi, int'($urandom_range(0, 2)));
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_4_stream.md
FFT_4_STREAM -- requirements
Module: fft_4_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each real or imaginary sample, signed two's complement.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  input sample valid.
REQ-005 in_ready  output  1  block accepts an input sample this cycle.
REQ-006 in_r, in_i  input  DATA_WIDTH each  input sample real and imaginary parts.
REQ-007 out_valid  output  1  output bin valid.
REQ-008 out_ready  input  1  downstream accepts an output bin.
REQ-009 out_r, out_i  output  DATA_WIDTH each  output bin real and imaginary parts.
REQ-010 out_index  output  2  bin number k of the current output (0..3).
REQ-011 out_last  output  1  high with bin 3.

Function
REQ-012 The block SHALL compute a 4-point DFT of four consecutively accepted samples x0..x3 (x0 first): X0=x0+x1+x2+x3; X1=(x0-x2)-j(x1-x3); X2=(x0+x2)-(x1+x3); X3=(x0-x2)+j(x1-x3).
REQ-013 Expanded: X1_r=(x0r-x2r)+(x1i-x3i), X1_i=(x0i-x2i)-(x1r-x3r), X3_r=(x0r-x2r)-(x1i-x3i), X3_i=(x0i-x2i)+(x1r-x3r).
REQ-014 Internal sums SHALL be computed at DATA_WIDTH+2 bits, sign-extended; no multipliers.
REQ-015 FSM states: LOAD, CALC, UNLOAD.
REQ-016 LOAD: in_ready=1, out_valid=0; a sample is accepted when in_valid&&in_ready at a clock edge; a 2-bit load counter advances per accepted sample.
REQ-017 LOAD->CALC on acceptance of the 4th sample; counter wraps to 0.
REQ-018 CALC lasts exactly one cycle: in_ready=0, out_valid=0; the four bins are registered at its closing edge; CALC->UNLOAD.
REQ-019 out_valid SHALL first be high in the second cycle after the edge that accepted x3.
REQ-020 UNLOAD: in_ready=0, out_valid=1; bins emitted in natural order 0,1,2,3; out_index and out_last track the emitted bin.
REQ-021 The current bin is consumed when out_valid&&out_ready at an edge; with out_ready low, out_r, out_i, out_index and out_last SHALL hold unchanged.
REQ-022 Consumption of bin 3 -> LOAD; in_ready high in the following cycle.
REQ-023 in_valid while in_ready=0 SHALL be ignored: no sample captured, no state change.
REQ-024 Gaps in in_valid during LOAD SHALL not lose or reorder partially loaded samples.

Reset
REQ-025 Reset assertion SHALL force LOAD immediately, in any state including mid-LOAD or mid-UNLOAD.
REQ-026 Reset SHALL clear the load counter and discard partial frames.
REQ-027 Reset values: in_ready=1 once rst_n deasserts, out_valid=0, out_r=0, out_i=0, out_index=0, out_last=0.
REQ-028 The first sample accepted after reset SHALL be x0.

Configuration
REQ-029 Macro FFT_SCALE_EN defined: each output = (DATA_WIDTH+2)-bit result arithmetically shifted right by 2 (floor, i.e. divide by N=4); cannot overflow.
REQ-030 FFT_SCALE_EN undefined: each output = low DATA_WIDTH bits of the result (modulo wrap, no saturation).
REQ-031 Port list and timing SHALL be identical in both builds.

Verification
REQ-032 DATA_WIDTH=16, unscaled, real inputs 4,8,0,0 -> bins (12,0),(4,-8),(-4,0),(4,8); out_last only on bin 3.
REQ-033 Same stimulus, FFT_SCALE_EN defined -> (3,0),(1,-2),(-1,0),(1,2).
REQ-034 Four real inputs 0x7FFF, unscaled -> X0=(0xFFFC,0), X1..X3=0; scaled -> X0=(0x7FFF,0).
REQ-035 Input impulse (1,1),0,0,0 with in_valid gaps -> all four bins (1,1) unscaled; in_ready low from CALC through bin 3 consumption.
REQ-036 out_ready held low 5 cycles during bin 1 -> out_r/out_i/out_index stable; in_valid pulses ignored; then bins 1..3 complete in order.
REQ-037 rst_n pulsed low during bin 2 -> out_valid=0 and in_ready=1 after release; the next 4 samples produce a correct, fresh frame.
